// File: rtl/pll_freq_gen_pkg.sv
// Shared types and constants for the PLL output-frequency generator.
// Imported by pll_period_div and pll_freq_gen.
package pll_freq_gen_pkg;

  localparam int          DIV_W_DEFAULT = 72;
  localparam logic [31:0] PERIOD_SAT    = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CALC      = 3'd1,
    WAIT_EDGE = 3'd2,
    RUN       = 3'd3,
    HOLD      = 3'd4
  } state_e;

  // Clamp a wide quotient to 32 bits: any set upper bit means overflow.
  function automatic logic [31:0] sat_period(input logic       hi_nonzero,
                                             input logic [31:0] lo);
    return hi_nonzero ? PERIOD_SAT : lo;
  endfunction

endpackage

// File: rtl/pll_period_div.sv
// Sequential restoring divider: one quotient bit per clock, DIV_W clocks per divide.
// Quotient is floor(numerator/denominator) saturated to 32 bits; a zero divisor finishes at once.
module pll_period_div
  import pll_freq_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] numerator,
  input  logic [31:0]      denominator,
  output logic             done,
  output logic [31:0]      quotient,
  output logic             div_by_zero
);

  localparam int               CNT_W     = $clog2(DIV_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

  logic [DIV_W-1:0] shreg_q, shreg_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      den_q, den_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      quot_q, quot_d;
  logic             dbz_q, dbz_d;

  logic [32:0]      rem_shift_s;
  logic [31:0]      rem_diff_s;
  logic             qbit_s;
  logic [DIV_W-1:0] shreg_next_s;

  // Shift-subtract step and control sequencing.
  always_comb begin
    rem_shift_s  = {rem_q, shreg_q[DIV_W-1]};
    qbit_s       = (rem_shift_s >= {1'b0, den_q});
    rem_diff_s   = rem_shift_s[31:0] - den_q;
    shreg_next_s = {shreg_q[DIV_W-2:0], qbit_s};

    shreg_d = shreg_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    dbz_d   = dbz_q;

    if (start) begin
      shreg_d = numerator;
      rem_d   = 32'd0;
      den_d   = denominator;
      cnt_d   = '0;
      if (denominator == 32'd0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        quot_d = PERIOD_SAT;
        dbz_d  = 1'b1;
      end else begin
        busy_d = 1'b1;
        dbz_d  = 1'b0;
      end
    end else if (busy_q) begin
      // The numerator register fills with quotient bits from the bottom.
      shreg_d = shreg_next_s;
      rem_d   = qbit_s ? rem_diff_s : rem_shift_s[31:0];
      cnt_d   = cnt_q + CNT_W'(1);
      if (cnt_q == LAST_STEP) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        quot_d = sat_period(|shreg_next_s[DIV_W-1:32], shreg_next_s[31:0]);
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      rem_q   <= 32'd0;
      den_q   <= 32'd0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 32'd0;
      dbz_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
    end
  end

  assign done        = done_q;
  assign quotient    = quot_q;
  assign div_by_zero = dbz_q;

endmodule

// File: rtl/pll_freq_gen.sv
// PLL output-frequency generator: out_period = ref_period*D*O/M, square wave on the clk timebase.
// Optional rising-edge counter output high_count when PLL_FREQ_GEN_EDGE_COUNT_EN is defined.
module pll_freq_gen
  import pll_freq_gen_pkg::*;
#(
  parameter int TICK_PS = 100,
  parameter int DIV_W   = DIV_W_DEFAULT
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        PWRDWN,
  input  logic        period_stable,
  input  logic        ref_in,
  input  logic [31:0] M_1000,
  input  logic [7:0]  D,
  input  logic [31:0] O_1000,
  input  logic [31:0] ref_period_1000,
  output logic        out,
  output logic [31:0] out_period_length_1000
`ifdef PLL_FREQ_GEN_EDGE_COUNT_EN
  ,
  output logic [31:0] high_count
`endif
);

  localparam logic [33:0] ACC_STEP = 34'(2 * TICK_PS);

  state_e      state_q, state_d;
  logic        out_q, out_d;
  logic [33:0] acc_q, acc_d;
  logic [31:0] per_q, per_d;
  logic        sync1_q, sync2_q, sync3_q;
  logic        rise_s;
  logic        div_start_s;
  logic        div_done_s;
  logic        div_dbz_s;
  logic [31:0] div_quot_s;
  logic [71:0] prod_s;
  logic [33:0] sum_s;

  assign prod_s = 72'(ref_period_1000) * 72'(D) * 72'(O_1000);
  assign rise_s = sync2_q & ~sync3_q;

  pll_period_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk         (clk),
    .rst         (RST),
    .start       (div_start_s),
    .numerator   (DIV_W'(prod_s)),
    .denominator (M_1000),
    .done        (div_done_s),
    .quotient    (div_quot_s),
    .div_by_zero (div_dbz_s)
  );

  // Next-state and output logic; losing period_stable or powering down always wins.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    acc_d       = acc_q;
    per_d       = per_q;
    div_start_s = 1'b0;
    sum_s       = acc_q + ACC_STEP;

    if (!period_stable || PWRDWN) begin
      state_d = IDLE;
      out_d   = 1'b0;
      acc_d   = 34'd0;
    end else begin
      case (state_q)
        IDLE: begin
          out_d       = 1'b0;
          acc_d       = 34'd0;
          div_start_s = 1'b1;
          state_d     = CALC;
        end
        CALC: begin
          out_d = 1'b0;
          if (div_done_s) begin
            per_d = div_quot_s;
            if (div_dbz_s || (div_quot_s == 32'd0)) begin
              state_d = HOLD;
            end else begin
              state_d = WAIT_EDGE;
            end
          end else begin
            state_d = CALC;
          end
        end
        WAIT_EDGE: begin
          if (rise_s) begin
            out_d   = 1'b1;
            acc_d   = 34'd0;
            state_d = RUN;
          end else begin
            out_d   = 1'b0;
            state_d = WAIT_EDGE;
          end
        end
        RUN: begin
          // Periods at or below one step would let acc grow without bound.
          if ({2'b00, per_q} <= ACC_STEP) begin
            out_d = ~out_q;
            acc_d = 34'd0;
          end else if (sum_s >= {2'b00, per_q}) begin
            out_d = ~out_q;
            acc_d = sum_s - {2'b00, per_q};
          end else begin
            acc_d = sum_s;
          end
        end
        HOLD: begin
          out_d = 1'b0;
          acc_d = 34'd0;
        end
        default: begin
          state_d = IDLE;
          out_d   = 1'b0;
          acc_d   = 34'd0;
        end
      endcase
    end
  end

  // Main state registers.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= IDLE;
      out_q   <= 1'b0;
      acc_q   <= 34'd0;
      per_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      per_q   <= per_d;
    end
  end

  // Two-flop synchronizer for ref_in plus history flop for rise detection.
  always_ff @(posedge clk) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= ref_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign out                    = out_q;
  assign out_period_length_1000 = per_q;

`ifdef PLL_FREQ_GEN_EDGE_COUNT_EN
  logic [31:0] hc_q, hc_d;

  // Count out rising edges since period_stable went high, saturating.
  always_comb begin
    hc_d = hc_q;
    if (!period_stable) begin
      hc_d = 32'd0;
    end else if (out_d && !out_q && (hc_q != PERIOD_SAT)) begin
      hc_d = hc_q + 32'd1;
    end else begin
      hc_d = hc_q;
    end
  end

  // Edge counter register.
  always_ff @(posedge clk) begin
    if (RST) begin
      hc_q <= 32'd0;
    end else begin
      hc_q <= hc_d;
    end
  end

  assign high_count = hc_q;
`endif

endmodule

// File: tb/tb_pll_freq_gen.sv
// Directed self-checking bench for pll_freq_gen with TICK_PS=100 (clk period 100 ps).
// Exercises high_count as well when PLL_FREQ_GEN_EDGE_COUNT_EN is defined.
`timescale 1ps/1ps
module tb_pll_freq_gen;

  localparam int          TICK = 100;
  localparam logic [31:0] SAT  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        RST;
  logic        PWRDWN;
  logic        period_stable;
  logic        ref_in;
  logic [31:0] M_1000;
  logic [7:0]  D;
  logic [31:0] O_1000;
  logic [31:0] ref_period_1000;
  logic        out;
  logic [31:0] opl;
`ifdef PLL_FREQ_GEN_EDGE_COUNT_EN
  logic [31:0] high_count;
`endif

  int checks = 0;
  int errors = 0;
  int rises, first, last, mn, mx, avg, highs;

  always #(TICK / 2) clk = ~clk;

  pll_freq_gen #(
    .TICK_PS (TICK),
    .DIV_W   (72)
  ) dut (
    .clk                    (clk),
    .RST                    (RST),
    .PWRDWN                 (PWRDWN),
    .period_stable          (period_stable),
    .ref_in                 (ref_in),
    .M_1000                 (M_1000),
    .D                      (D),
    .O_1000                 (O_1000),
    .ref_period_1000        (ref_period_1000),
    .out                    (out),
    .out_period_length_1000 (opl)
`ifdef PLL_FREQ_GEN_EDGE_COUNT_EN
    ,
    .high_count             (high_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic configure(input logic [31:0] refp, input logic [31:0] m,
                           input logic [7:0] d, input logic [31:0] o);
    @(negedge clk); period_stable = 1'b0;
    @(negedge clk);
    ref_period_1000 = refp;
    M_1000          = m;
    D               = d;
    O_1000          = o;
    @(negedge clk); period_stable = 1'b1;
  endtask

  task automatic settle_per(input string tag, input logic [31:0] exp);
    repeat (120) @(posedge clk);
    #1;
    chk(tag, opl, exp);
  endtask

  task automatic fire_ref_edge(input string tag);
    @(negedge clk); ref_in = 1'b0;
    repeat (4) @(negedge clk);
    ref_in = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk({tag, "_pre"}, out, 64'd0);
    @(posedge clk); #1;
    chk({tag, "_rise"}, out, 64'd1);
  endtask

  task automatic measure(input int ncyc, output int n_rise, output int f, output int l,
                         output int mi, output int ma);
    logic prev;
    int   prev_rise;
    n_rise = 0; f = -1; l = -1; mi = 1 << 30; ma = 0;
    prev = out; prev_rise = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      if (out === 1'b1 && prev === 1'b0) begin
        n_rise++;
        if (f < 0) f = i;
        if (prev_rise >= 0) begin
          if (i - prev_rise < mi) mi = i - prev_rise;
          if (i - prev_rise > ma) ma = i - prev_rise;
        end
        prev_rise = i;
        l = i;
      end
      prev = out;
    end
  endtask

  task automatic hold_check(input string tag);
    int n_high;
    @(negedge clk); ref_in = 1'b0;
    repeat (4) @(negedge clk);
    ref_in = 1'b1;
    n_high = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (out !== 1'b0) n_high++;
    end
    chk(tag, n_high, 64'd0);
  endtask

  initial begin
    RST = 1'b1; PWRDWN = 1'b0; period_stable = 1'b0; ref_in = 1'b0;
    M_1000 = 32'd0; D = 8'd0; O_1000 = 32'd0; ref_period_1000 = 32'd0;

    // Reset for two edges while ref_in toggles.
    @(negedge clk); ref_in = 1'b1;
    @(negedge clk); ref_in = 1'b0;
    chk("rst_out", out, 64'd0);
    chk("rst_period", opl, 64'd0);
`ifdef PLL_FREQ_GEN_EDGE_COUNT_EN
    chk("rst_high_count", high_count, 64'd0);
`endif
    RST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out", out, 64'd0);

    // 20 ns reference, unity ratio: 200-cycle output period.
    configure(32'd20000, 32'd1000, 8'd1, 32'd1000);
    settle_per("c1_period", 32'd20000);
    fire_ref_edge("c1");
    measure(10000, rises, first, last, mn, mx);
    chk("c1_rises_49_51", (rises >= 49 && rises <= 51), 64'd1);
    chk("c1_min_interval", mn, 64'd200);
    chk("c1_max_interval", mx, 64'd200);

    // out has just risen; dropping period_stable must clear it next edge.
    @(negedge clk); period_stable = 1'b0;
    @(posedge clk); #1;
    chk("drop_out", out, 64'd0);
    chk("drop_period_kept", opl, 64'd20000);
`ifdef PLL_FREQ_GEN_EDGE_COUNT_EN
    chk("drop_high_count", high_count, 64'd0);
`endif

    // 10 ns reference: 100-cycle output period.
    configure(32'd10000, 32'd1000, 8'd1, 32'd1000);
    settle_per("c2_period", 32'd10000);
    fire_ref_edge("c2");
    measure(10000, rises, first, last, mn, mx);
    chk("c2_rises_99_101", (rises >= 99 && rises <= 101), 64'd1);
    chk("c2_min_interval", mn, 64'd100);
    chk("c2_max_interval", mx, 64'd100);
`ifdef PLL_FREQ_GEN_EDGE_COUNT_EN
    chk("c2_high_count", high_count, rises + 1);
`endif

    // Non-integer ratio: 5600*1*1000/5000 = 1120 ps, periods of 11 or 12 ticks.
    configure(32'd5600, 32'd5000, 8'd1, 32'd1000);
    settle_per("c3_period", 32'd1120);
    fire_ref_edge("c3");
    measure(10000, rises, first, last, mn, mx);
    avg = (rises > 1) ? ((last - first) * TICK) / (rises - 1) : 0;
    chk("c3_avg_1020_1220", (avg >= 1020 && avg <= 1220), 64'd1);
    chk("c3_jitter_11_12", (mn >= 11 && mx <= 12), 64'd1);

    // Period below one step: toggle every cycle.
    configure(32'd150, 32'd1000, 8'd1, 32'd1000);
    settle_per("c4_period", 32'd150);
    fire_ref_edge("c4");
    measure(100, rises, first, last, mn, mx);
    chk("c4_min_interval", mn, 64'd2);
    chk("c4_max_interval", mx, 64'd2);

    // Quotient beyond 32 bits saturates.
    configure(32'd4000000000, 32'd1, 8'd200, 32'd1000000);
    settle_per("sat_period", SAT);

    // Zero result parks in HOLD.
    configure(32'd1, 32'd1000, 8'd1, 32'd1);
    settle_per("zero_period", 32'd0);
    hold_check("zero_out_low");

    // Divide by zero saturates and parks in HOLD.
    configure(32'd20000, 32'd0, 8'd1, 32'd1000);
    settle_per("m0_period", SAT);
    hold_check("m0_out_low");

    // Power-down during RUN.
    configure(32'd20000, 32'd1000, 8'd1, 32'd1000);
    settle_per("pd_period", 32'd20000);
    fire_ref_edge("pd");
    @(negedge clk); PWRDWN = 1'b1;
    @(posedge clk); #1;
    chk("pd_out", out, 64'd0);
    chk("pd_period_kept", opl, 64'd20000);
    repeat (5) @(posedge clk);
    #1;
    chk("pd_out_stays", out, 64'd0);
    PWRDWN = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_freq_gen.md
Name: pll_freq_gen

Overview:
Synthesizable model of the PLL output-frequency generator. It derives the output period from the measured reference period and the multiply/divide settings: out_period = ref_period * D * O / M, with M and O in fixed-point ×1000. It produces a square wave `out` on a fast timebase clock `clk`, phase-aligned to the first reference rising edge. It sits behind the reference-period measurement block in the PLL/MMCM simulation core.

Parameters:
- TICK_PS, default 100: period of `clk` in ps. Sets the timing resolution of `out`.
- DIV_W, default 72: numerator width used by the period divider.

Ports:
- clk  in  1  timebase clock; all logic is synchronous to it.
- RST  in  1  synchronous, active-high reset.
- PWRDWN  in  1  power-down; forces `out` low.
- period_stable  in  1  high while ref_period_1000 is valid.
- ref_in  in  1  reference signal, sampled as data (not used as a clock).
- M_1000  in  32  multiplier ×1000.
- D  in  8  input divider, integer.
- O_1000  in  32  output divider ×1000.
- ref_period_1000  in  32  reference period in ps (ns×1000).
- out  out  1  generated clock.
- out_period_length_1000  out  32  computed output period in ps.

Behaviour:
- Reset (RST=1 at a clk edge):
  - out=0, out_period_length_1000=0, accumulator=0.
  - Synchronizer flops cleared; state=IDLE.
  - RST has priority over all other inputs.
- IDLE:
  - out=0.
  - Moves to CALC on the first cycle with period_stable=1 and PWRDWN=0.
- CALC:
  - Latch N = ref_period_1000*D*O_1000 (72-bit, unsigned). Run a restoring divide N/M_1000, one quotient bit per cycle, DIV_W cycles.
  - Result is floor, saturated to 0xFFFFFFFF.
  - Write the result to out_period_length_1000, then go to WAIT_EDGE.
  - M_1000=0: result 0xFFFFFFFF; go to HOLD (out stays 0).
  - Result 0: go to HOLD.
- WAIT_EDGE:
  - ref_in passes through a 2-flop synchronizer plus an edge register.
  - On the detected 0→1 transition: out←1, acc←0, state→RUN.
  - out therefore rises 3 clk cycles after ref_in rises at a sample point.
- RUN, each cycle:
  - acc ← acc + 2*TICK_PS.
  - If the new sum ≥ P (P = out_period_length_1000): out toggles and acc ← sum − P. Otherwise acc ← sum.
  - The average half-period is exactly P/2 ps; jitter is at most one tick.
  - P ≤ 2*TICK_PS: out toggles every cycle (clamped).
  - acc is 34 bits, so no overflow.
- Leaving active states:
  - period_stable=0 in any state other than IDLE: next cycle out=0, acc=0, state=IDLE. out_period_length_1000 keeps its last value.
  - A change of ref_period_1000, M_1000, D or O_1000 takes effect only via a period_stable low→high cycle. Inputs are latched in CALC.
- PWRDWN=1:
  - Same as period_stable=0: out=0, state=IDLE.
  - out_period_length_1000 retained.
- HOLD: out=0 until period_stable=0, PWRDWN=1 or RST.

Optional Feature:
- PLL_FREQ_GEN_EDGE_COUNT_EN defined:
  - Adds output high_count [31:0]: the number of out 0→1 transitions since period_stable last went high.
  - Synchronously cleared while period_stable=0 or RST=1.
  - Saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Package pll_freq_gen_pkg:
  - state enum: IDLE, CALC, WAIT_EDGE, RUN, HOLD.
  - DIV_W default.
  - PERIOD_SAT = 32'hFFFFFFFF.
- Sub-module pll_period_div: sequential restoring divider.
  - Inputs: start, numerator[71:0], denominator[31:0].
  - Outputs: done, quotient[31:0] (saturated), div_by_zero.
- Edge counter (optional feature) is inline logic.

Test Plan:
- RST=1 for 2 cycles while ref_in toggles → out=0, out_period_length_1000=0.
- M=1000, D=1, O=1000, ref_period=20000, ref_in period 20 ns, period_stable=1 → out rises 3 cycles after the first sampled ref_in rise; out_period_length_1000=20000; in 1000 ns, 50±1 out rising edges.
- Same ratio, period_stable 0→1 with ref_period=10000 → out_period_length_1000=10000; 100±1 rising edges per 1000 ns.
- ref_period=5600, M=5000, D=1, O=1000 → out_period_length_1000=1120; measured average period 1120 ps ±TICK_PS.
- M_1000=0 → out_period_length_1000=0xFFFFFFFF; out stays 0. Drop period_stable mid-RUN → out=0 on the next cycle.
- PWRDWN=1 during RUN → out=0 next cycle. With PLL_FREQ_GEN_EDGE_COUNT_EN: high_count clears when period_stable=0 and equals the rising edges counted afterwards.
